// File: rtl/display_scan_pkg.sv
// rtl/display_scan_pkg.sv - shared types and constants for the display scan controller
//
// Purpose : scan FSM state encoding and the BCD nibble width used by
//           display_scan_ctrl and its interval timer.
// Ports   : none (package).

package display_scan_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - interval counter with restart and terminal-count flag
//
// Purpose : counts clk cycles inside one BLANK or SHOW interval.
// Ports   : clk   - clock, rising edge
//           rst   - synchronous active-high reset, clears the count
//           load  - restart the interval (count returns to 0 next edge)
//           last  - count value of the final cycle of the current interval
//           tc    - high during the final cycle of the interval

module scan_timer #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] last,
   output logic          tc
);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tc = (count == last);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed BCD display scanner with anti-ghost blanking
//
// Purpose : cycles through NUM_DIGITS common-enable lines, inserting a blank
//           interval before each digit, and double-buffers the display value
//           so a new value only appears at a frame boundary.
// Ports   : clk, rst        - clock and synchronous active-high reset
//           enable          - scan when high, all digits off when low
//           load_valid/ready/data - display value handshake (digit 0 in [3:0])
//           bcd_out         - nibble to the shared BCD-to-7-segment decoder
//           bi_n            - decoder blanking input, active low
//           digit_en_n      - digit common enables, active low
//           frame_done      - one-cycle pulse in the first cycle of each new frame
// Config  : LEADING_ZERO_BLANK_EN - blank leading zero digits (digit 0 always shown)

module display_scan_ctrl
   import display_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic                           load_valid,
   output logic                           load_ready,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
   output logic [NIBBLE_W-1:0]            bcd_out,
   output logic                           bi_n,
   output logic [NUM_DIGITS-1:0]          digit_en_n,
   output logic                           frame_done
);

   localparam int MAX_C = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW    = $clog2(MAX_C) + 1;
   localparam int IW    = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   scan_state_t                              state, state_nx;
   logic [IW-1:0]                            idx, idx_nx;
   logic [NUM_DIGITS-1:0][NIBBLE_W-1:0]      active, active_nx;
   logic [NUM_DIGITS-1:0][NIBBLE_W-1:0]      shadow, shadow_nx;
   logic                                     pending, pending_nx;
   logic                                     frame_nx, commit;
   logic [NIBBLE_W-1:0]                      bcd_nx;
   logic                                     bi_nx;
   logic [NUM_DIGITS-1:0]                    den_nx;
   logic                                     tmr_load, tmr_tc;
   logic [CW-1:0]                            tmr_last;

   // The timer restarts whenever the interval ends or the scan is idle/stopping,
   // so each interval always begins at count 0.
   assign tmr_load = (state == ST_OFF) || !enable || tmr_tc;
   assign tmr_last = (state == ST_SHOW) ? DWELL_LAST : BLANK_LAST;

   scan_timer #(.CW(CW)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .last (tmr_last),
      .tc   (tmr_tc)
   );

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      active_nx  = active;
      shadow_nx  = shadow;
      pending_nx = pending;
      frame_nx   = 1'b0;
      commit     = 1'b0;

      case (state)
         ST_OFF: begin
            idx_nx = '0;
            commit = pending;
            if (enable) state_nx = ST_BLANK;
         end
         ST_BLANK: begin
            if (!enable) begin
               state_nx = ST_OFF;
               idx_nx   = '0;
            end else if (tmr_tc) begin
               state_nx = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (!enable) begin
               state_nx = ST_OFF;
               idx_nx   = '0;
            end else if (tmr_tc) begin
               state_nx = ST_BLANK;
               if (idx == IDX_LAST) begin
                  idx_nx   = '0;
                  frame_nx = 1'b1;
                  commit   = pending;
               end else begin
                  idx_nx = idx + IW'(1);
               end
            end
         end
         default: begin
            state_nx = ST_OFF;
            idx_nx   = '0;
         end
      endcase

      // Commit uses the registered pending flag, so a value accepted on the
      // wrap edge itself waits for the next wrap.
      if (commit) begin
         active_nx  = shadow;
         pending_nx = 1'b0;
      end
      if (load_valid && load_ready) begin
         shadow_nx  = load_data;
         pending_nx = 1'b1;
      end
   end

   // Outputs are decoded from the next-state values and registered alongside
   // the state, so they always describe the current state register.
   always_comb begin
      bcd_nx = '0;
      bi_nx  = 1'b0;
      den_nx = '1;
      if (state_nx == ST_SHOW) begin
         den_nx[idx_nx] = 1'b0;
         bcd_nx         = active_nx[idx_nx];
         bi_nx          = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
         begin
            logic lz_blank;
            lz_blank = (idx_nx != '0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if ((i >= int'(idx_nx)) && (active_nx[i] != '0)) lz_blank = 1'b0;
            end
            if (lz_blank) bi_nx = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_OFF;
         idx        <= '0;
         active     <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         load_ready <= 1'b1;
         bcd_out    <= '0;
         bi_n       <= 1'b0;
         digit_en_n <= '1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         active     <= active_nx;
         shadow     <= shadow_nx;
         pending    <= pending_nx;
         load_ready <= ~pending_nx;
         bcd_out    <= bcd_nx;
         bi_n       <= bi_nx;
         digit_en_n <= den_nx;
         frame_done <= frame_nx;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl

module tb_display_scan_ctrl;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_data;
   logic [3:0]  bcd_out;
   logic        bi_n;
   logic [3:0]  digit_en_n;
   logic        frame_done;

   int n_checks;
   int n_errors;

   display_scan_ctrl #(
      .NUM_DIGITS   (4),
      .DWELL_CYCLES (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .bcd_out    (bcd_out),
      .bi_n       (bi_n),
      .digit_en_n (digit_en_n),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_bi(input logic [15:0] val, input int d);
`ifdef LEADING_ZERO_BLANK_EN
      logic [15:0] v;
      v = val >> (4 * d);
      return !((d > 0) && (v == 16'h0));
`else
      return 1'b1;
`endif
   endfunction

   task automatic check_off(input string tag);
      check({tag, "_den"}, digit_en_n, 4'hF);
      check({tag, "_bi"},  bi_n,       1'b0);
      check({tag, "_bcd"}, bcd_out,    4'h0);
   endtask

   // One full 24-cycle frame starting at the first BLANK cycle of digit 0.
   // first    : frame entered from OFF, so no frame_done at its start
   // rdy0     : load_ready expected at frame start
   // load_at  : frame cycle after which load_valid is offered for one edge (-1 none)
   task automatic run_frame(input logic [15:0] val, input bit first, input bit rdy0,
                            input int load_at, input logic [15:0] ld);
      int c;
      logic [3:0] den;
      logic       rdy;
      c = 0;
      for (int d = 0; d < 4; d++) begin
         den = ~(4'b0001 << d);
         for (int b = 0; b < 2; b++) begin
            step;
            rdy = rdy0 && !((load_at >= 0) && (c > load_at));
            check("blank_den",  digit_en_n, 4'hF);
            check("blank_bi",   bi_n,       1'b0);
            check("frame_done", frame_done, (d == 0 && b == 0 && !first));
            check("load_ready", load_ready, rdy);
            load_valid = (c == load_at);
            load_data  = ld;
            c++;
         end
         for (int s = 0; s < 4; s++) begin
            step;
            rdy = rdy0 && !((load_at >= 0) && (c > load_at));
            check("show_den",   digit_en_n, den);
            check("show_bcd",   bcd_out,    val[4*d +: 4]);
            check("show_bi",    bi_n,       exp_bi(val, d));
            check("frame_done", frame_done, 1'b0);
            check("load_ready", load_ready, rdy);
            load_valid = (c == load_at);
            load_data  = ld;
            c++;
         end
      end
   endtask

   task automatic load_while_off(input logic [15:0] v);
      enable = 1'b0;
      step;
      check_off("off");
      load_valid = 1'b1;
      load_data  = v;
      step;
      check("off_accept_ready", load_ready, 1'b0);
      load_valid = 1'b0;
      step;
      check("off_commit_ready", load_ready, 1'b1);
      enable = 1'b1;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b1;
      enable     = 1'b0;
      load_valid = 1'b0;
      load_data  = 16'h0;

      // reset state
      repeat (3) step;
      check_off("rst");
      check("rst_fd",    frame_done, 1'b0);
      check("rst_ready", load_ready, 1'b1);

      // scan with nothing loaded: zeros, frame_done every 24 cycles
      rst    = 1'b0;
      enable = 1'b1;
      run_frame(16'h0000, 1'b1, 1'b1, -1, 16'h0);
      run_frame(16'h0000, 1'b0, 1'b1, -1, 16'h0);

      // load while OFF, then scan; mid-frame load shows at next frame
      load_while_off(16'h4321);
      run_frame(16'h4321, 1'b1, 1'b1, -1, 16'h0);
      run_frame(16'h4321, 1'b0, 1'b1, 9, 16'h9876);
      run_frame(16'h9876, 1'b0, 1'b1, -1, 16'h0);

      // load accepted on the wrap edge waits a whole frame; nibbles >9 pass through
      run_frame(16'h9876, 1'b0, 1'b1, 23, 16'hFACB);
      run_frame(16'h9876, 1'b0, 1'b0, -1, 16'h0);
      run_frame(16'hFACB, 1'b0, 1'b1, -1, 16'h0);

      // drop enable during SHOW of digit 2, then restart
      for (int c = 0; c < 15; c++) step;
      check("idx2_den", digit_en_n, 4'hB);
      check("idx2_bcd", bcd_out,    4'hA);
      enable = 1'b0;
      step;
      check_off("dis");
      check("dis_fd", frame_done, 1'b0);
      step;
      check_off("dis2");
      enable = 1'b1;
      run_frame(16'hFACB, 1'b1, 1'b1, -1, 16'h0);

      // reset mid-SHOW overrides enable and load
      for (int c = 0; c < 5; c++) step;
      check("pre_rst_den", digit_en_n, 4'hE);
      rst        = 1'b1;
      load_valid = 1'b1;
      load_data  = 16'h1234;
      step;
      check_off("rst_mid");
      check("rst_mid_ready", load_ready, 1'b1);
      check("rst_mid_fd",    frame_done, 1'b0);
      step;
      rst        = 1'b0;
      load_valid = 1'b0;
      run_frame(16'h0000, 1'b1, 1'b1, -1, 16'h0);

      // leading-zero patterns
      load_while_off(16'h0050);
      run_frame(16'h0050, 1'b1, 1'b1, -1, 16'h0);
      load_while_off(16'h0000);
      run_frame(16'h0000, 1'b1, 1'b1, -1, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
